// File: rtl/screen_write_queue_pkg.sv
// Shared types and helpers for the screen write queue.
// Falls back to default SCREEN_ADDRESS / SCREEN_RANGE when the platform config has not defined them.
`ifndef SCREEN_ADDRESS
`define SCREEN_ADDRESS 32'h0001_0000
`endif
`ifndef SCREEN_RANGE
`define SCREEN_RANGE 32'h0000_2000
`endif

package screen_write_queue_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CHAR_W    = 16;
    localparam int unsigned DEPTH_DEF = 8;
    localparam int unsigned FB_AW_DEF = 12;

    // One framebuffer cell as written by the CPU halfword store
    typedef struct packed {
        logic [7:0] attr;
        logic [7:0] chr;
    } screen_char_t;

    function automatic logic [ADDR_W-1:0] screen_offset(input logic [ADDR_W-1:0] addr,
                                                        input logic [ADDR_W-1:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/screen_write_queue_if.sv
// Bus-decoder / framebuffer side signals of the screen write queue.
interface screen_write_queue_if
    import screen_write_queue_pkg::*;
#(
    parameter int unsigned FB_AW = FB_AW_DEF
);
    logic                screen_wen;
    logic [ADDR_W-1:0]   data_addr;
    logic [DATA_W-1:0]   wdata;
    logic                fb_ready;
    logic                cpu_stall;
    logic                fb_we;
    logic [FB_AW-1:0]    fb_addr;
    logic [CHAR_W-1:0]   fb_data;
    logic                busy;

    modport master (
        output screen_wen, data_addr, wdata, fb_ready,
        input  cpu_stall, fb_we, fb_addr, fb_data, busy
    );

    modport slave (
        input  screen_wen, data_addr, wdata, fb_ready,
        output cpu_stall, fb_we, fb_addr, fb_data, busy
    );
endinterface

// File: rtl/screen_write_queue_sync_fifo.sv
// Synchronous FIFO owning pointers and count, with a rewrite port on the newest entry.
module screen_write_queue_sync_fifo #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    input  logic                       rewrite,
    input  logic [WIDTH-1:0]           rewrite_data,
    output logic [WIDTH-1:0]           newest_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] newest_ptr;
    logic             do_push;
    logic             do_pop;
    logic             do_rewrite;

    assign full       = (count == (PTR_W+1)'(DEPTH));
    assign empty      = (count == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign do_rewrite = rewrite && !empty;
    assign newest_ptr = tail - PTR_W'(1);
    assign pop_data    = mem[head];
    assign newest_data = mem[newest_ptr];

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PTR_W'(1);
            if (do_pop)  head <= head + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= push_data;
        end else if (do_rewrite) begin
            mem[newest_ptr] <= rewrite_data;
        end
    end

endmodule

// File: rtl/screen_write_queue.sv
// Write buffer between bus decoder and character framebuffer; stalls the CPU only when full.
// Optional SCREEN_WQ_COALESCE_EN merges a store into the newest entry when the index matches.
module screen_write_queue
    import screen_write_queue_pkg::*;
#(
    parameter int unsigned       DEPTH = DEPTH_DEF,
    parameter int unsigned       FB_AW = FB_AW_DEF,
    parameter logic [ADDR_W-1:0] BASE  = `SCREEN_ADDRESS
) (
    input  logic                 clk,
    input  logic                 reset,
    screen_write_queue_if.slave  bus
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = FB_AW + CHAR_W;

    logic [ADDR_W-1:0]  offset;
    logic [FB_AW-1:0]   index;
    screen_char_t       char_in;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [ENTRY_W-1:0] newest_entry;
    logic [PTR_W:0]     count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               coalesce_hit;
    logic               unused_bits;

    // Halfword-aligned byte address to cell index, truncated to the framebuffer width
    assign offset     = screen_offset(bus.data_addr, BASE);
    assign index      = offset[FB_AW:1];
    assign char_in    = screen_char_t'(bus.wdata[CHAR_W-1:0]);
    assign push_entry = {index, char_in};

`ifdef SCREEN_WQ_COALESCE_EN
    // Newest entry may only be rewritten if it is not leaving through the pop port this cycle
    assign coalesce_hit = bus.screen_wen && !empty
                          && (newest_entry[ENTRY_W-1:CHAR_W] == index)
                          && !(pop && (count == (PTR_W+1)'(1)));
    assign unused_bits  = ^{offset[ADDR_W-1:FB_AW+1], offset[0], bus.wdata[DATA_W-1:CHAR_W]};
`else
    assign coalesce_hit = 1'b0;
    assign unused_bits  = ^{offset[ADDR_W-1:FB_AW+1], offset[0], bus.wdata[DATA_W-1:CHAR_W],
                            newest_entry, count};
`endif

    assign push = bus.screen_wen && !full && !coalesce_hit;
    assign pop  = !empty && bus.fb_ready && !reset;

    screen_write_queue_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .push_data    (push_entry),
        .pop          (pop),
        .pop_data     (head_entry),
        .rewrite      (coalesce_hit),
        .rewrite_data (push_entry),
        .newest_data  (newest_entry),
        .full         (full),
        .empty        (empty),
        .count        (count)
    );

    assign bus.cpu_stall = bus.screen_wen && full && !coalesce_hit;
    assign bus.fb_we     = pop;
    assign bus.fb_addr   = head_entry[ENTRY_W-1:CHAR_W];
    assign bus.fb_data   = head_entry[CHAR_W-1:0];
    assign bus.busy      = !empty;

endmodule
